input_debounce: RTL and testbench



---
 rtl/input_debounce.sv | 175 +++++++++++++++++
 tb/tb_input_debounce.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/input_debounce.sv
// Purpose: synchronise and debounce the key1 push-button and the slide switches; optional key auto-repeat under `REPEAT_EN.
// Latency: an input change that stays stable is reported DEBOUNCE_CYCLES+3 cycles after the pad is first sampled (2 sync flops + arm + count).
// Backpressure: none. Pulses last one cycle and are never held, so consumers must sample every cycle.
module input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20'd1000000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned REPEAT_DELAY    = 32'd25000000,
  parameter int unsigned REPEAT_PERIOD   = 32'd5000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_raw,
  input  logic [SW_W-1:0] sw_raw,
  output logic            key_level,
  output logic            key_press,
  output logic            key_release,
  output logic [SW_W-1:0] sw_out,
  output logic            sw_changed
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] PRESSED = 2'd2;
  localparam logic [1:0] DISARM  = 2'd3;

  // Reject parameter values the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'h00FF_FFFF ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("input_debounce: illegal parameter value");
  end

  // Key is normalised so that 1 always means "pressed" from here on.
  logic key_norm;
  assign key_norm = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

  logic            k_m, k_s;
  logic [SW_W-1:0] sw_m, sw_s;
  logic [1:0]      state;
  logic [CW-1:0]   kcnt;
  logic [SW_W-1:0] sw_cand;
  logic [CW-1:0]   scnt;
  logic            rep_fire;

  // Two-flop synchronisers for the asynchronous pads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      k_m  <= 1'b0;
      k_s  <= 1'b0;
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      k_m  <= key_norm;
      k_s  <= k_m;
      sw_m <= sw_raw;
      sw_s <= sw_m;
    end
  end

  // Key FSM: a level change is accepted only after DEBOUNCE_CYCLES stable cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      kcnt        <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (k_s) begin
            state <= ARM;
            kcnt  <= '0;
          end
        end
        ARM: begin
          if (!k_s) begin
            state <= IDLE;
            kcnt  <= '0;
          end else if (kcnt == CNT_MAX) begin
            state     <= PRESSED;
            kcnt      <= '0;
            key_level <= 1'b1;
            key_press <= 1'b1;
          end else begin
            kcnt <= kcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!k_s) begin
            state <= DISARM;
            kcnt  <= '0;
          end else if (rep_fire) begin
            key_press <= 1'b1;
          end
        end
        default: begin // DISARM
          if (k_s) begin
            // Bounce back to pressed: no pulse, level never dropped.
            state <= PRESSED;
            kcnt  <= '0;
          end else if (kcnt == CNT_MAX) begin
            state       <= IDLE;
            kcnt        <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            kcnt <= kcnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef REPEAT_EN
  localparam logic [31:0] RD_MAX = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RP_MAX = 32'(REPEAT_PERIOD - 1);

  logic [31:0] rcnt;
  logic        rep_phase; // 0 = waiting for first repeat, 1 = periodic repeats

  assign rep_fire = (state == PRESSED) && k_s &&
                    (rep_phase ? (rcnt == RP_MAX) : (rcnt == RD_MAX));

  // Auto-repeat timer: runs only while stably pressed, restarts on every (re)entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rcnt      <= '0;
      rep_phase <= 1'b0;
    end else if (state != PRESSED || !k_s) begin
      rcnt      <= '0;
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      rcnt      <= '0;
      rep_phase <= 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Switch vector: one shared window, so multi-bit changes commit together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_cand    <= '0;
      scnt       <= '0;
      sw_out     <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= 1'b0;
      if (sw_s != sw_cand) begin
        sw_cand <= sw_s;
        scnt    <= '0;
      end else if (sw_cand != sw_out) begin
        if (scnt == CNT_MAX) begin
          sw_out     <= sw_cand;
          sw_changed <= 1'b1;
          scnt       <= '0;
        end else begin
          scnt <= scnt + 1'b1;
        end
      end else begin
        scnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with DEBOUNCE_CYCLES=4, active-low key, 16 switches.
// Expected values are hand-derived: an input stable from step 1 is reported after step 7.
module tb_input_debounce;

`ifdef REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        key_raw;
  logic [15:0] sw_raw;
  logic        key_level;
  logic        key_press;
  logic        key_release;
  logic [15:0] sw_out;
  logic        sw_changed;

  int vectors;
  int miscompares;

  input_debounce #(
    .DEBOUNCE_CYCLES(4),
    .KEY_ACTIVE_LOW (1'b1),
    .SW_W           (16),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .sw_raw     (sw_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .sw_out     (sw_out),
    .sw_changed (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic p, input logic r, input logic l,
                         input logic [15:0] so, input logic sc);
    chk({tag, ".key_press"},   {15'd0, key_press},   {15'd0, p});
    chk({tag, ".key_release"}, {15'd0, key_release}, {15'd0, r});
    chk({tag, ".key_level"},   {15'd0, key_level},   {15'd0, l});
    chk({tag, ".sw_out"},      sw_out,               so);
    chk({tag, ".sw_changed"},  {15'd0, sw_changed},  {15'd0, sc});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset with key pressed and switches all high: everything stays zero.
    rst = 1'b0; key_raw = 1'b0; sw_raw = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    end

    // Reset exit with key released: switches commit once after 7 edges, no key pulses.
    rst = 1'b1; key_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_all("rst_exit", 1'b0, 1'b0, 1'b0, (i >= 7) ? 16'hFFFF : 16'h0000, i == 7);
    end

    // Clean press.
    key_raw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_all("press", i == 7, 1'b0, i >= 7, 16'hFFFF, 1'b0);
    end

    // Clean release.
    key_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_all("release", 1'b0, i == 7, i < 7, 16'hFFFF, 1'b0);
    end

    // 3-cycle bounce while idle: nothing accepted.
    for (int i = 1; i <= 12; i++) begin
      key_raw = (i <= 3) ? 1'b0 : 1'b1;
      step();
      chk_all("bounce_idle", 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    end

    // Press, then 2-cycle bounce while pressed: no release.
    key_raw = 1'b0;
    for (int i = 1; i <= 8; i++) step();
    chk("bp_setup.key_level", {15'd0, key_level}, 16'h0001);
    for (int i = 1; i <= 12; i++) begin
      key_raw = (i <= 2) ? 1'b1 : 1'b0;
      step();
      chk("bounce_pressed.key_release", {15'd0, key_release}, 16'h0000);
      chk("bounce_pressed.key_level",   {15'd0, key_level},   16'h0001);
    end
    key_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("bp_release.key_release", {15'd0, key_release}, {15'd0, i == 7});
      chk("bp_release.key_level",   {15'd0, key_level},   {15'd0, i < 7});
    end

    // Switches to zero, then 0x0010 with bit 5 glitching: one clean commit.
    sw_raw = 16'h0000;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_all("sw_zero", 1'b0, 1'b0, 1'b0, (i >= 7) ? 16'h0000 : 16'hFFFF, i == 7);
    end
    for (int i = 1; i <= 13; i++) begin
      sw_raw = (i == 3 || i == 4) ? 16'h0030 : 16'h0010;
      step();
      chk_all("sw_glitch", 1'b0, 1'b0, 1'b0, (i >= 11) ? 16'h0010 : 16'h0000, i == 11);
    end

    // Key and switches change together: both reported in the same cycle.
    key_raw = 1'b0; sw_raw = 16'hABCD;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_all("simul", i == 7, 1'b0, i >= 7, (i >= 7) ? 16'hABCD : 16'h0010, i == 7);
    end
    key_raw = 1'b1;
    for (int i = 1; i <= 8; i++) step();
    chk("simul_rel.key_level", {15'd0, key_level}, 16'h0000);

    // Long hold: auto-repeat pulses only when the feature is built in.
    key_raw = 1'b0;
    for (int i = 1; i <= 27; i++) begin
      step();
      chk("repeat.key_press", {15'd0, key_press},
          {15'd0, (i == 7) || (REP_ON && (i == 17 || i == 20 || i == 23 || i == 26))});
      chk("repeat.key_level", {15'd0, key_level}, {15'd0, i >= 7});
    end
    key_raw = 1'b1;
    for (int i = 1; i <= 8; i++) step();
    chk("repeat_rel.key_level", {15'd0, key_level}, 16'h0000);

    // Reset pulsed during ARM discards progress; full latency afterwards.
    key_raw = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("arm_pre.key_press", {15'd0, key_press}, 16'h0000);
    end
    rst = 1'b0;
    step();
    chk_all("arm_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_all("arm_post", i == 7, 1'b0, i >= 7, (i >= 7) ? 16'hABCD : 16'h0000, i == 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
